// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with data-memory handshake, branch resolve and MEM/WB register
//   inputs  : EX/MEM fields (alu_c_in, rt_data_in, npc_in, zero_in, branch_in, memr/memw/regw/mem2r_in, reg_rd_in)
//   dmem    : dm_req/dm_we/dm_addr/dm_wdata out, dm_rdata/dm_ack in
//   control : mem_stall (holds EX/MEM and upstream), pc_src (take branch), dm_err (sticky)
//   MEM/WB  : wb_alu_c, wb_rdata, wb_rd, wb_regw, wb_mem2r
module mem_access_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_c_in,
   input  logic [31:0] rt_data_in,
   input  logic [31:0] npc_in,
   input  logic        zero_in,
   input  logic [1:0]  branch_in,
   input  logic        memr_in,
   input  logic        memw_in,
   input  logic        regw_in,
   input  logic        mem2r_in,
   input  logic [4:0]  reg_rd_in,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        mem_stall,
   output logic        pc_src,
   output logic        dm_err,
   output logic [31:0] wb_alu_c,
   output logic [31:0] wb_rdata,
   output logic [4:0]  wb_rd,
   output logic        wb_regw,
   output logic        wb_mem2r
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0] rlat_q;
   logic mem_op, mis, is_ld, tmo;
   logic unused_npc;
   assign unused_npc = ^npc_in;
   assign mem_op = memr_in | memw_in;
   assign mis    = alu_c_in[1:0] != 2'b00;
   assign is_ld  = memr_in & ~memw_in;
   // abort on the ACCESS cycle in which the counter would reach TIMEOUT
   assign tmo = (TIMEOUT != 0) && state_q == ACCESS && !dm_ack && cnt_q == CNT_W'(TIMEOUT - 1);
   assign mem_stall = (state_q == IDLE && mem_op) || state_q == ACCESS;
   assign pc_src = ~mem_stall & (branch_in == 2'b11 | (branch_in == 2'b01 & zero_in) | (branch_in == 2'b10 & ~zero_in));
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (mem_op) state_d = mis ? DONE : ACCESS;
         ACCESS:  if (dm_ack || tmo) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rlat_q   <= '0;
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_wdata <= '0;
         dm_err   <= 1'b0;
         wb_alu_c <= '0;
         wb_rdata <= '0;
         wb_rd    <= '0;
         wb_regw  <= 1'b0;
         wb_mem2r <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && mem_op && !mis) begin
            dm_req   <= 1'b1;
            dm_we    <= memw_in;
            dm_addr  <= {alu_c_in[31:2], 2'b00};
            dm_wdata <= rt_data_in;
            cnt_q    <= '0;
         end
         if (state_q == IDLE && mem_op && mis) begin
            dm_err <= 1'b1;
            rlat_q <= '0;
         end
         if (state_q == ACCESS) begin
            if (dm_ack) begin
               dm_req <= 1'b0;
               rlat_q <= dm_rdata;
            end else if (tmo) begin
               dm_req <= 1'b0;
               dm_err <= 1'b1;
               rlat_q <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         // EX/MEM inputs are held through the stall, so misalignment is still visible in DONE
         if (!mem_stall) begin
            wb_alu_c <= alu_c_in;
            wb_rd    <= reg_rd_in;
            wb_regw  <= regw_in & ~(mem_op & mis);
            wb_mem2r <= mem2r_in;
            wb_rdata <= is_ld ? rlat_q : '0;
         end else begin
            wb_regw  <= 1'b0;
            wb_mem2r <= 1'b0;
         end
      end
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs: ALU result, store data, NPC, ZERO, branch code, memory and writeback controls, and destination register.
- Runs a request/acknowledge handshake to a variable-latency data memory.
- Resolves branches and raises a stall that holds EX/MEM and all upstream stages.
- Contains the MEM/WB pipeline register that feeds the writeback stage.

Parameters:
- TIMEOUT, 16: max cycles in ACCESS without dm_ack before the access is aborted; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- alu_c_in  in  32  ALU result; memory byte address for loads/stores
- rt_data_in  in  32  store data
- npc_in  in  32  branch/jump target computed in EX
- zero_in  in  1  ALU zero flag
- branch_in  in  2  00 none, 01 BEQ, 10 BNE, 11 unconditional jump
- memr_in  in  1  load
- memw_in  in  1  store
- regw_in  in  1  register write enable
- mem2r_in  in  1  writeback selects memory data
- reg_rd_in  in  5  destination register
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_addr  out  32  word-aligned address
- dm_wdata  out  32  write data
- dm_rdata  in  32  read data; valid when dm_ack=1
- dm_ack  in  1  access complete
- mem_stall  out  1  hold EX/MEM and upstream; EX/MEM write enable = ~mem_stall
- pc_src  out  1  take branch; PC loads npc_in
- dm_err  out  1  sticky error: misaligned access or timeout
- wb_alu_c  out  32  MEM/WB ALU result
- wb_rdata  out  32  MEM/WB load data
- wb_rd  out  5  MEM/WB destination register
- wb_regw  out  1  MEM/WB register write enable
- wb_mem2r  out  1  MEM/WB writeback select

Behaviour:
- Reset:
  - Every registered output is 0: dm_req, dm_we, dm_addr, dm_wdata, dm_err, and all wb_* outputs.
  - FSM goes to IDLE; timeout counter and read-data latch are cleared.
  - mem_stall and pc_src are combinational and evaluate to 0 while no access is pending.
- mem_op = memr_in | memw_in. If both are set, the store takes priority: dm_we=1 and no load data is returned.
- Alignment: misaligned means alu_c_in[1:0] != 0. A misaligned mem_op issues no request, sets dm_err, and goes straight to DONE with a read latch of 0. wb_regw is forced to 0 for that load.
- FSM states:
  - IDLE: mem_op=0 means no stall, and MEM/WB captures this cycle. mem_op=1 and aligned means mem_stall=1 and next state is ACCESS; dm_addr={alu_c_in[31:2],2'b00}, dm_wdata and dm_we are registered on this edge.
  - ACCESS: dm_req=1, mem_stall=1. dm_addr, dm_wdata and dm_we stay stable until dm_ack. On dm_ack: latch dm_rdata (loads), clear dm_req, go to DONE. On timeout: counter reaches TIMEOUT, so abort, clear dm_req, set dm_err, latch 0, go to DONE.
  - DONE: mem_stall=0. EX/MEM advances and MEM/WB captures on this edge; next state is IDLE.
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Memory op: 2 + (number of ACCESS cycles); minimum 3 when dm_ack arrives in the first ACCESS cycle.
- Counter resets on entry to ACCESS and increments every ACCESS cycle without ack.
- dm_ack outside ACCESS is ignored.
- MEM/WB update, on a non-stall cycle:
  - wb_alu_c<=alu_c_in, wb_rd<=reg_rd_in, wb_regw<=regw_in, wb_mem2r<=mem2r_in.
  - wb_rdata<=latch for loads, else 0.
- MEM/WB on a stall cycle: bubble. wb_regw<=0 and wb_mem2r<=0; other wb_* fields hold.
- pc_src = ~mem_stall & (branch_in==11 | (branch_in==01 & zero_in) | (branch_in==10 & ~zero_in)).
- dm_err clears only on rst.
- rst asserted mid-ACCESS: dm_req drops at the next edge, the outstanding ack is ignored, and no MEM/WB write occurs.

Test Plan:
- R-type, alu_c_in=0x1234, reg_rd_in=5, regw_in=1, no mem_op -> mem_stall=0; next edge wb_alu_c=0x1234, wb_rd=5, wb_regw=1.
- Load addr 0x40, memory acks on the 3rd ACCESS cycle with 0xDEADBEEF -> mem_stall high for 4 cycles; dm_addr=0x40, dm_we=0; after DONE, wb_rdata=0xDEADBEEF, wb_mem2r=1; wb_regw=0 during the stall cycles.
- Store addr 0x80, data 0xA5A5A5A5, ack in first ACCESS cycle -> dm_req high 1 cycle, dm_we=1, dm_wdata=0xA5A5A5A5; 3 cycles total.
- Load addr 0x41 -> no dm_req, dm_err=1, wb_regw=0, wb_rdata=0. Load addr 0x100 with ack never given -> abort after 16 ACCESS cycles, dm_err=1, dm_req=0.
- Branch cases, no mem_op -> BEQ zero=1 gives pc_src=1; BNE zero=1 gives pc_src=0; branch_in=11 gives pc_src=1.
- rst pulsed during ACCESS, ack arrives 1 cycle later -> all outputs 0, FSM IDLE, ack ignored, no MEM/WB write.
